board_input_debounce: RTL and testbench

- Input-side counterpart to the board LED output logic: samples raw asynchronous switch and button pins, synchronises and debounces them.
- Presents clean, stable levels plus one-cycle rise and fall pulses to user logic.
- One instance per board input group (e.g. 16 slide switches, 5 push buttons), clocked from the board clock domain.

---
 rtl/board_input_debounce.sv | 94 +++++++++
 tb/tb_board_input_debounce.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/board_input_debounce.sv
// Two-flop synchroniser plus tick-based debouncer for a group of board inputs.
// Outputs a stable level per channel and registered one-cycle rise/fall/changed pulses.
module board_input_debounce #(
  parameter int WIDTH        = 16,
  parameter int TICKBITS     = 17,
  parameter int STABLE_TICKS = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] STATE,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             CHANGED
);

  localparam int CW = $clog2(STABLE_TICKS) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0]    sync1_q;
  logic [WIDTH-1:0]    sync2_q;
  logic [TICKBITS-1:0] pre_q;
  logic [TICKBITS-1:0] pre_d;
  logic [CW-1:0]       cnt_q [WIDTH];
  logic [CW-1:0]       cnt_d [WIDTH];
  logic [WIDTH-1:0]    state_q;
  logic [WIDTH-1:0]    state_d;
  logic [WIDTH-1:0]    rise_q;
  logic [WIDTH-1:0]    rise_d;
  logic [WIDTH-1:0]    fall_q;
  logic [WIDTH-1:0]    fall_d;
  logic                changed_q;
  logic                changed_d;
  logic                tick_s;

  assign tick_s = &pre_q;

  // Next-state: any agreement with the current level restarts the window.
  always_comb begin
    pre_d   = pre_q + TICKBITS'(1);
    state_d = state_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == state_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick_s && (cnt_q[i] == CNT_LAST)) begin
        state_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
        rise_d[i]  = sync2_q[i];
        fall_d[i]  = ~sync2_q[i];
      end else if (tick_s) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      pre_q     <= '0;
      state_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= IN;
      sync2_q   <= sync1_q;
      pre_q     <= pre_d;
      state_q   <= state_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign STATE   = state_q;
  assign RISE    = rise_q;
  assign FALL    = fall_q;
  assign CHANGED = changed_q;

endmodule

// File: tb/tb_board_input_debounce.sv
// Self-checking bench: directed table, corner-case sequences and random stimulus
// compared against a disagreement-duration reference model.
`timescale 1ns/100ps
module tb_board_input_debounce;

  localparam int W      = 4;
  localparam int TB     = 2;
  localparam int ST     = 3;
  localparam int PERIOD = 1 << TB;
  localparam int THRESH = PERIOD * (ST - 1) + 1;

  logic         CLK;
  logic         RST;
  logic [W-1:0] IN;
  logic [W-1:0] STATE;
  logic [W-1:0] RISE;
  logic [W-1:0] FALL;
  logic         CHANGED;

  int total;
  int bad;

  board_input_debounce #(.WIDTH(W), .TICKBITS(TB), .STABLE_TICKS(ST)) dut (
    .CLK(CLK), .RST(RST), .IN(IN),
    .STATE(STATE), .RISE(RISE), .FALL(FALL), .CHANGED(CHANGED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: a channel flips on a tick edge once its synchronised
  // input has disagreed with the debounced level for THRESH consecutive edges.
  int           edge_n;
  logic [W-1:0] hist[$];
  int           run[W];
  logic [W-1:0] m_state;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;

  task automatic model_reset();
    edge_n = 0;
    hist.delete();
    for (int c = 0; c < W; c++) run[c] = 0;
    m_state = '0;
    m_rise  = '0;
    m_fall  = '0;
  endtask

  task automatic model_edge();
    logic [W-1:0] s;
    edge_n++;
    s = (edge_n >= 3) ? hist[edge_n - 3] : '0;
    hist.push_back(IN);
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < W; c++) begin
      if (s[c] == m_state[c]) begin
        run[c] = 0;
      end else begin
        run[c]++;
        if ((edge_n % PERIOD) == 0 && run[c] >= THRESH) begin
          m_state[c] = s[c];
          if (s[c]) m_rise[c] = 1'b1;
          else      m_fall[c] = 1'b1;
          run[c] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Drive IN from a negedge, clock one edge, then compare against the model.
  task automatic step(input logic [W-1:0] v);
    IN = v;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    chk("model", {STATE, RISE, FALL, CHANGED},
        {m_state, m_rise, m_fall, |(m_rise | m_fall)});
  endtask

  task automatic do_reset();
    RST = 1'b1;
    IN  = '0;
    @(negedge CLK);
    @(negedge CLK);
    chk("reset_outs", {STATE, RISE, FALL, CHANGED}, 32'd0);
    RST = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [W-1:0] in;
    logic [W-1:0] st;
    logic [W-1:0] rs;
    logic [W-1:0] fl;
    logic         ch;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int acc;
    int cnt_r;
    int cnt_c;
    logic [W-1:0] v;
    total = 0;
    bad   = 0;
    RST   = 1'b1;
    IN    = '0;

    // Steady high: row i is edge i+1, flip expected at edge 12.
    for (int i = 0; i < 14; i++) begin
      tbl[i].in = 4'b0001;
      tbl[i].st = (i >= 11) ? 4'b0001 : 4'b0000;
      tbl[i].rs = (i == 11) ? 4'b0001 : 4'b0000;
      tbl[i].fl = 4'b0000;
      tbl[i].ch = (i == 11);
    end
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].in);
      chk("steady_tbl", {STATE, RISE, FALL, CHANGED},
          {tbl[i].st, tbl[i].rs, tbl[i].fl, tbl[i].ch});
    end

    // Release: exactly one FALL[0], no RISE.
    cnt_r = 0; acc = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b0000);
      if (FALL == 4'b0001) cnt_r++;
      acc = acc | int'(RISE);
    end
    chk("release_fall_cnt", cnt_r, 1);
    chk("release_no_rise", acc, 0);
    chk("release_state", STATE, 4'b0000);

    // Glitch on IN[1] straddling a tick must be rejected.
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      step((i < 5) ? 4'b0010 : 4'b0000);
      acc = acc | int'(STATE[1]) | int'(RISE[1]) | int'(CHANGED);
    end
    chk("glitch_reject", acc, 0);

    // Bounce then settle high on IN[2].
    acc = 0; cnt_r = 0;
    for (int i = 0; i < 20; i++) begin
      step(((i / 3) % 2 == 0) ? 4'b0100 : 4'b0000);
      acc = acc | int'(STATE[2]);
    end
    chk("bounce_no_change", acc, 0);
    for (int i = 0; i < 20; i++) begin
      step(4'b0100);
      if (RISE[2]) cnt_r++;
    end
    chk("bounce_rise_cnt", cnt_r, 1);
    for (int i = 0; i < 20; i++) step(4'b0000);

    // Simultaneous flip on bits 3:2.
    cnt_r = 0; cnt_c = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b1100);
      if (RISE == 4'b1100) cnt_r++;
      if (CHANGED) cnt_c++;
    end
    chk("simul_rise_cnt", cnt_r, 1);
    chk("simul_changed_cnt", cnt_c, 1);
    chk("simul_state", STATE, 4'b1100);

    // Async reset mid-count, then re-debounce from the new release.
    for (int i = 0; i < 9; i++) step(4'b1101);
    #1 RST = 1'b1;
    #0.5;
    chk("async_rst_outs", {STATE, RISE, FALL, CHANGED}, 32'd0);
    #0.5 RST = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      step(4'b1101);
      if (i == 10) chk("rst_relaunch_e11", STATE, 4'b0000);
    end
    chk("rst_relaunch_e12", {STATE, RISE}, {4'b1101, 4'b1101});

    // Random stimulus against the model.
    do_reset();
    v = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < W; c++) begin
        if ($urandom_range(0, 11) == 0) v[c] = ~v[c];
      end
      step(v);
      chk("rise_fall_excl", int'(RISE & FALL), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
